// File: rtl/bpi_seq_pkg.sv
// rtl/bpi_seq_pkg.sv - command codes, state encodings and strobe bundle shared by the BPI sequencer
package bpi_seq_pkg;

    localparam logic [4:0] CMD_NOOP       = 5'h00;
    localparam logic [4:0] CMD_READ_1     = 5'h02;
    localparam logic [4:0] CMD_WRITE_N    = 5'h03;
    localparam logic [4:0] CMD_READ_ARRAY = 5'h05;
    localparam logic [4:0] CMD_READ_ES    = 5'h07;
    localparam logic [4:0] CMD_CLR_SR     = 5'h09;
    localparam logic [4:0] CMD_BUF_PROG   = 5'h0C;
    localparam logic [4:0] CMD_BUF_WRT_N  = 5'h0D;
    localparam logic [4:0] CMD_BUF_CONF   = 5'h0E;
    localparam logic [4:0] CMD_SET_CNFG   = 5'h12;

    typedef enum logic [4:0] {
        ST_RESET         = 5'd0,
        ST_SET_ASYNCH    = 5'd1,
        ST_GAP           = 5'd2,
        ST_RD_ARRAY      = 5'd3,
        ST_COMPLETE      = 5'd4,
        ST_IDLE          = 5'd5,
        ST_SIMPLE        = 5'd6,
        ST_ISSUE_CMD     = 5'd7,
        ST_READ_STATUS   = 5'd8,
        ST_CHECK_PEC     = 5'd9,
        ST_CHECK_STAT    = 5'd10,
        ST_BUF_PROG      = 5'd11,
        ST_READ_BUF_STAT = 5'd12,
        ST_CHECK_BUF     = 5'd13,
        ST_BUF_WRT_N     = 5'd14,
        ST_WRITE_N       = 5'd15,
        ST_BUF_CONF      = 5'd16,
        ST_LK_ISSUE      = 5'd17,
        ST_RES_MODE      = 5'd18,
        ST_READ_ES       = 5'd19,
        ST_CNFRM_LK      = 5'd20,
        ST_RPT_ERROR     = 5'd21,
        ST_CLR_SR        = 5'd22
    } seq_state_e;

    typedef struct packed {
        logic check_pec;
        logic check_buf;
        logic check_stat;
        logic cnfrm_lk;
        logic read_es_state;
        logic set_asynch;
        logic rpt_error;
        logic seq_cmplt;
        logic seqr_idle;
    } seq_strb_t;

endpackage

// File: rtl/bpi_seq_gap_timer.sv
// rtl/bpi_seq_gap_timer.sv - inter-command gap down-counter holding the state to resume afterwards
module bpi_seq_gap_timer
    import bpi_seq_pkg::*;
#(
    parameter int GAP_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [4:0] target_in,
    output logic       done,
    output logic [4:0] target
);

    logic [3:0] cnt_q, cnt_d;
    logic [4:0] tgt_q, tgt_d;

    // Loaded on the edge that enters GAP, so the first GAP cycle already sees GAP_CYC-1.
    always_comb begin
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        if (load) begin
            cnt_d = 4'(GAP_CYC - 1);
            tgt_d = target_in;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 4'd0;
            tgt_q <= ST_RESET;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
        end
    end

    assign done   = (cnt_q == 4'd0);
    assign target = tgt_q;

endmodule

// File: rtl/bpi_seq_engine.sv
// rtl/bpi_seq_engine.sv - BPI flash command sequencer with bounded busy polling and lock retry
module bpi_seq_engine
    import bpi_seq_pkg::*;
#(
    parameter int                CMD_W     = 5,
    parameter int                GAP_CYC   = 1,
    parameter int                POLL_W    = 16,
    parameter logic [POLL_W-1:0] MAX_POLL  = POLL_W'(16'hFFFF),
    parameter int                MAX_RETRY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              lk_unlk,
    input  logic              buf_prog,
    input  logic              std_seq,
    input  logic              simple_cmd,
    input  logic [CMD_W-1:0]  seq_cmnd,
    input  logic              seq_done,
    input  logic              ack,
    input  logic              error,
    input  logic              lk_ok,
    input  logic              pec_busy,
    input  logic              noop_seq,
    output logic [CMD_W-1:0]  command,
    output logic              check_pec,
    output logic              check_buf,
    output logic              check_stat,
    output logic              cnfrm_lk,
    output logic              read_es_state,
    output logic              set_asynch,
    output logic              rpt_error,
    output logic              seq_cmplt,
    output logic              seqr_idle,
    output logic              timeout_err,
    output logic              lk_fail,
    output logic [POLL_W-1:0] poll_cnt,
    output logic [2:0]        retry_cnt,
    output logic [4:0]        state_out
);

    seq_state_e        state_q, state_d;
    seq_state_e        gap_tgt;
    logic [4:0]        gap_target;
    logic              gap_load, gap_done;
    logic [CMD_W-1:0]  command_q, command_d;
    seq_strb_t         strb_q, strb_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d, poll_inc;
    logic [2:0]        retry_cnt_q, retry_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              lk_fail_q, lk_fail_d;
    logic              is_check, poll_hit, lk_miss;

    bpi_seq_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
        .CLK       (CLK),
        .RST       (RST),
        .load      (gap_load),
        .target_in (gap_tgt),
        .done      (gap_done),
        .target    (gap_target)
    );

    always_comb begin
        state_d  = state_q;
        gap_load = 1'b0;
        gap_tgt  = ST_RD_ARRAY;
        is_check = (state_q == ST_CHECK_PEC) || (state_q == ST_CHECK_BUF);
        poll_inc = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + POLL_W'(1);
        poll_hit = pec_busy && (MAX_POLL != '0) && (poll_inc == MAX_POLL);
        lk_miss  = !lk_ok && (retry_cnt_q == 3'(MAX_RETRY));
        case (state_q)
            ST_RESET:         state_d = ST_SET_ASYNCH;
            ST_SET_ASYNCH:    if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_RD_ARRAY; end
            ST_GAP:           if (gap_done) state_d = seq_state_e'(gap_target);
            ST_RD_ARRAY:      if (seq_done) state_d = ST_COMPLETE;
            ST_COMPLETE:      if (noop_seq) state_d = ST_IDLE;
            ST_IDLE: begin
                if (lk_unlk)         state_d = ST_LK_ISSUE;
                else if (buf_prog)   state_d = ST_BUF_PROG;
                else if (std_seq)    state_d = ST_ISSUE_CMD;
                else if (simple_cmd) state_d = ST_SIMPLE;
            end
            ST_SIMPLE:        if (seq_done) state_d = ST_COMPLETE;
            ST_ISSUE_CMD:     if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_READ_STATUS; end
            ST_READ_STATUS:   if (seq_done) state_d = ST_CHECK_PEC;
            ST_CHECK_PEC: begin
                if (poll_hit)      state_d = ST_RPT_ERROR;
                else if (pec_busy) state_d = ST_READ_STATUS;
                else               state_d = ST_CHECK_STAT;
            end
            ST_CHECK_STAT: begin
                if (error) state_d = ST_RPT_ERROR;
                else begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_RD_ARRAY; end
            end
            ST_BUF_PROG:      if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_READ_BUF_STAT; end
            ST_READ_BUF_STAT: if (seq_done) state_d = ST_CHECK_BUF;
            ST_CHECK_BUF: begin
                if (poll_hit)      state_d = ST_RPT_ERROR;
                else if (pec_busy) state_d = ST_BUF_PROG;
                else               state_d = ST_BUF_WRT_N;
            end
            ST_BUF_WRT_N:     if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_WRITE_N; end
            ST_WRITE_N:       if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_BUF_CONF; end
            ST_BUF_CONF:      if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_READ_STATUS; end
            ST_LK_ISSUE:      if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_RES_MODE; end
            ST_RES_MODE:      if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_READ_ES; end
            ST_READ_ES:       if (seq_done) state_d = ST_CNFRM_LK;
            ST_CNFRM_LK: begin
                if (lk_ok) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_RD_ARRAY; end
                else if (lk_miss) state_d = ST_RPT_ERROR;
                else              state_d = ST_LK_ISSUE;
            end
            ST_RPT_ERROR:     if (ack) state_d = ST_CLR_SR;
            ST_CLR_SR:        if (seq_done) begin state_d = ST_GAP; gap_load = 1'b1; gap_tgt = ST_RD_ARRAY; end
            default:          state_d = ST_RESET;
        endcase
    end

    // Counters and sticky flags; IDLE entry and CLR_SR entry take priority over updates.
    always_comb begin
        poll_cnt_d    = poll_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        timeout_err_d = timeout_err_q;
        lk_fail_d     = lk_fail_q;
        if (is_check && pec_busy)
            poll_cnt_d = poll_inc;
        if (is_check && poll_hit)
            timeout_err_d = 1'b1;
        if ((state_q == ST_CNFRM_LK) && lk_miss)
            lk_fail_d = 1'b1;
        if ((state_d == ST_LK_ISSUE) && (state_q != ST_LK_ISSUE) && (retry_cnt_q != 3'd7))
            retry_cnt_d = retry_cnt_q + 3'd1;
        if (state_d == ST_IDLE) begin
            poll_cnt_d  = '0;
            retry_cnt_d = 3'd0;
        end
        if (state_d == ST_CLR_SR) begin
            timeout_err_d = 1'b0;
            lk_fail_d     = 1'b0;
        end
    end

    always_comb begin
        command_d = CMD_W'(CMD_NOOP);
        strb_d    = '0;
        case (state_d)
            ST_SET_ASYNCH: begin
                command_d         = CMD_W'(CMD_SET_CNFG);
                strb_d.set_asynch = 1'b1;
            end
            ST_RD_ARRAY:                         command_d = CMD_W'(CMD_READ_ARRAY);
            ST_COMPLETE:                         strb_d.seq_cmplt = 1'b1;
            ST_IDLE:                             strb_d.seqr_idle = 1'b1;
            ST_SIMPLE, ST_ISSUE_CMD, ST_LK_ISSUE: command_d = seq_cmnd;
            ST_READ_STATUS, ST_READ_BUF_STAT:    command_d = CMD_W'(CMD_READ_1);
            ST_CHECK_PEC:                        strb_d.check_pec = 1'b1;
            ST_CHECK_STAT:                       strb_d.check_stat = 1'b1;
            ST_BUF_PROG:                         command_d = CMD_W'(CMD_BUF_PROG);
            ST_CHECK_BUF:                        strb_d.check_buf = 1'b1;
            ST_BUF_WRT_N:                        command_d = CMD_W'(CMD_BUF_WRT_N);
            ST_WRITE_N:                          command_d = CMD_W'(CMD_WRITE_N);
            ST_BUF_CONF:                         command_d = CMD_W'(CMD_BUF_CONF);
            ST_RES_MODE:                         command_d = CMD_W'(CMD_READ_ES);
            ST_READ_ES: begin
                command_d            = CMD_W'(CMD_READ_1);
                strb_d.read_es_state = 1'b1;
            end
            ST_CNFRM_LK:                         strb_d.cnfrm_lk = 1'b1;
            ST_RPT_ERROR:                        strb_d.rpt_error = 1'b1;
            ST_CLR_SR:                           command_d = CMD_W'(CMD_CLR_SR);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_RESET;
            command_q     <= '0;
            strb_q        <= '0;
            poll_cnt_q    <= '0;
            retry_cnt_q   <= 3'd0;
            timeout_err_q <= 1'b0;
            lk_fail_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            command_q     <= command_d;
            strb_q        <= strb_d;
            poll_cnt_q    <= poll_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            timeout_err_q <= timeout_err_d;
            lk_fail_q     <= lk_fail_d;
        end
    end

    assign command       = command_q;
    assign check_pec     = strb_q.check_pec;
    assign check_buf     = strb_q.check_buf;
    assign check_stat    = strb_q.check_stat;
    assign cnfrm_lk      = strb_q.cnfrm_lk;
    assign read_es_state = strb_q.read_es_state;
    assign set_asynch    = strb_q.set_asynch;
    assign rpt_error     = strb_q.rpt_error;
    assign seq_cmplt     = strb_q.seq_cmplt;
    assign seqr_idle     = strb_q.seqr_idle;
    assign timeout_err   = timeout_err_q;
    assign lk_fail       = lk_fail_q;
    assign poll_cnt      = poll_cnt_q;
    assign retry_cnt     = retry_cnt_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_bpi_seq_engine.sv
// tb/tb_bpi_seq_engine.sv - table-driven command-trace bench for the BPI sequencer
module tb_bpi_seq_engine;
    import bpi_seq_pkg::*;

    localparam int CMD_W = 8;
    localparam int NV    = 12;

    logic             CLK = 1'b0;
    logic             RST;
    logic             lk_unlk, buf_prog, std_seq, simple_cmd;
    logic [CMD_W-1:0] seq_cmnd;
    logic             seq_done, ack, error, lk_ok, pec_busy, noop_seq;
    logic [CMD_W-1:0] command;
    logic             check_pec, check_buf, check_stat, cnfrm_lk, read_es_state, set_asynch;
    logic             rpt_error, seq_cmplt, seqr_idle, timeout_err, lk_fail;
    logic [15:0]      poll_cnt;
    logic [2:0]       retry_cnt;
    logic [4:0]       state_out;
    logic [10:0]      strb_all;

    assign strb_all = {check_pec, check_buf, check_stat, cnfrm_lk, read_es_state, set_asynch,
                       rpt_error, seq_cmplt, seqr_idle, timeout_err, lk_fail};

    bpi_seq_engine #(
        .CMD_W(CMD_W), .GAP_CYC(2), .POLL_W(16), .MAX_POLL(16'd4), .MAX_RETRY(3)
    ) dut (
        .CLK(CLK), .RST(RST),
        .lk_unlk(lk_unlk), .buf_prog(buf_prog), .std_seq(std_seq), .simple_cmd(simple_cmd),
        .seq_cmnd(seq_cmnd), .seq_done(seq_done), .ack(ack), .error(error), .lk_ok(lk_ok),
        .pec_busy(pec_busy), .noop_seq(noop_seq),
        .command(command), .check_pec(check_pec), .check_buf(check_buf), .check_stat(check_stat),
        .cnfrm_lk(cnfrm_lk), .read_es_state(read_es_state), .set_asynch(set_asynch),
        .rpt_error(rpt_error), .seq_cmplt(seq_cmplt), .seqr_idle(seqr_idle),
        .timeout_err(timeout_err), .lk_fail(lk_fail), .poll_cnt(poll_cnt),
        .retry_cnt(retry_cnt), .state_out(state_out)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  req;      // {lk_unlk, buf_prog, std_seq, simple_cmd}
        logic [7:0]  cmnd;
        logic [7:0]  busy_n;   // number of busy answers before pec_busy drops
        logic        lk_ok_v;
        logic        err_v;
        logic        sd_all;   // hold seq_done high in every cycle
        logic [15:0] poll;
        logic [2:0]  retry;
        logic [2:0]  flags;    // {rpt_error seen, timeout_err then, lk_fail then}
    } vec_t;

    vec_t  vecs [NV];
    string exp_tr [NV];
    int    passes = 0;
    int    total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    endtask

    // Trace format: first command, then "<zero cycles> <next command>" pairs.
    task automatic run_vec(input int idx);
        vec_t             v;
        string            tr, nm;
        int               zrun, nchk, cyc;
        logic [CMD_W-1:0] prev;
        logic [2:0]       flags;
        v = vecs[idx];
        tr = ""; zrun = 0; nchk = 0; cyc = 0; prev = '0; flags = 3'b000;
        nm = $sformatf("vec%0d", idx);
        {lk_unlk, buf_prog, std_seq, simple_cmd} = v.req;
        seq_cmnd = v.cmnd;
        seq_done = v.sd_all;
        @(negedge CLK);
        {lk_unlk, buf_prog, std_seq, simple_cmd} = 4'b0000;
        while (!seq_cmplt && cyc < 500) begin
            if (command != '0 && prev == '0) begin
                if (tr.len() == 0) tr = $sformatf("%02h", command);
                else tr = {tr, $sformatf(" %0d %02h", zrun, command)};
                zrun = 0;
            end else if (command == '0 && tr.len() != 0) begin
                zrun++;
            end
            prev = command;
            if (rpt_error && !flags[2]) flags = {1'b1, timeout_err, lk_fail};
            seq_done = v.sd_all | (command != '0);
            pec_busy = 1'b0;
            if (check_pec || check_buf) begin
                pec_busy = (nchk < int'(v.busy_n));
                nchk++;
            end
            error = check_stat & v.err_v;
            lk_ok = cnfrm_lk & v.lk_ok_v;
            ack   = rpt_error;
            @(negedge CLK);
            cyc++;
        end
        chk({nm, " finished"}, 64'(cyc < 500), 64'(1));
        chk_str({nm, " trace"}, tr, exp_tr[idx]);
        chk({nm, " poll_cnt"}, 64'(poll_cnt), 64'(v.poll));
        chk({nm, " retry_cnt"}, 64'(retry_cnt), 64'(v.retry));
        chk({nm, " report flags"}, 64'(flags), 64'(v.flags));
        chk({nm, " sticky cleared"}, 64'({timeout_err, lk_fail}), 64'(2'b00));
        seq_done = 1'b0; pec_busy = 1'b0; error = 1'b0; lk_ok = 1'b0; ack = 1'b0;
        noop_seq = 1'b1;
        @(negedge CLK);
        noop_seq = 1'b0;
        chk({nm, " idle"}, 64'({seqr_idle, poll_cnt, retry_cnt}), 64'({1'b1, 16'd0, 3'd0}));
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{4'b0000, 8'h00, 8'd0,  1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 3'b000};
        exp_tr[0]  = "12 2 05";
        vecs[1]  = '{4'b0001, 8'h11, 8'd0,  1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 3'b000};
        exp_tr[1]  = "11";
        vecs[2]  = '{4'b0010, 8'h0A, 8'd3,  1'b0, 1'b0, 1'b1, 16'd3, 3'd0, 3'b000};
        exp_tr[2]  = "0a 2 02 1 02 1 02 1 02 4 05";
        vecs[3]  = '{4'b0010, 8'h0A, 8'd0,  1'b0, 1'b1, 1'b0, 16'd0, 3'd0, 3'b100};
        exp_tr[3]  = "0a 2 02 3 09 2 05";
        vecs[4]  = '{4'b0100, 8'h00, 8'd0,  1'b0, 1'b0, 1'b1, 16'd0, 3'd0, 3'b000};
        exp_tr[4]  = "0c 2 02 1 0d 2 03 2 0e 2 02 4 05";
        vecs[5]  = '{4'b0100, 8'h00, 8'd1,  1'b0, 1'b0, 1'b0, 16'd1, 3'd0, 3'b000};
        exp_tr[5]  = "0c 2 02 1 0c 2 02 1 0d 2 03 2 0e 2 02 4 05";
        vecs[6]  = '{4'b1000, 8'h01, 8'd0,  1'b1, 1'b0, 1'b0, 16'd0, 3'd1, 3'b000};
        exp_tr[6]  = "01 2 07 2 02 3 05";
        vecs[7]  = '{4'b1000, 8'h01, 8'd0,  1'b0, 1'b0, 1'b1, 16'd0, 3'd3, 3'b101};
        exp_tr[7]  = "01 2 07 2 02 1 01 2 07 2 02 1 01 2 07 2 02 2 09 2 05";
        vecs[8]  = '{4'b0010, 8'h0A, 8'd99, 1'b0, 1'b0, 1'b0, 16'd4, 3'd0, 3'b110};
        exp_tr[8]  = "0a 2 02 1 02 1 02 1 02 2 09 2 05";
        vecs[9]  = '{4'b1111, 8'h01, 8'd0,  1'b1, 1'b0, 1'b0, 16'd0, 3'd1, 3'b000};
        exp_tr[9]  = "01 2 07 2 02 3 05";
        vecs[10] = '{4'b0111, 8'h0A, 8'd0,  1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 3'b000};
        exp_tr[10] = "0c 2 02 1 0d 2 03 2 0e 2 02 4 05";
        vecs[11] = '{4'b0011, 8'h0A, 8'd0,  1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 3'b000};
        exp_tr[11] = "0a 2 02 4 05";

        RST = 1'b1;
        {lk_unlk, buf_prog, std_seq, simple_cmd} = 4'b0000;
        seq_cmnd = '0; seq_done = 1'b0; ack = 1'b0; error = 1'b0;
        lk_ok = 1'b0; pec_busy = 1'b0; noop_seq = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset command", 64'(command), 64'(0));
        chk("reset strobes", 64'(strb_all), 64'(0));
        chk("reset counters", 64'({poll_cnt, retry_cnt}), 64'(0));
        chk("reset state", 64'(state_out), 64'(ST_RESET));

        RST = 1'b0;
        @(negedge CLK);
        chk("boot command", 64'(command), 64'(8'h12));
        chk("boot set_asynch", 64'(set_asynch), 64'(1));
        chk("boot state", 64'(state_out), 64'(ST_SET_ASYNCH));

        for (int i = 0; i < NV; i++) run_vec(i);

        buf_prog = 1'b1;
        @(negedge CLK);
        buf_prog = 1'b0;
        cyc = 0;
        while (command != 8'h03 && cyc < 200) begin
            seq_done = (command != '0);
            @(negedge CLK);
            cyc++;
        end
        chk("reach WRITE_N", 64'(state_out), 64'(ST_WRITE_N));
        seq_done = 1'b0;
        RST = 1'b1;
        #1;
        chk("midseq rst command", 64'(command), 64'(0));
        chk("midseq rst strobes", 64'(strb_all), 64'(0));
        chk("midseq rst state", 64'(state_out), 64'(ST_RESET));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reinit command", 64'(command), 64'(8'h12));
        chk("reinit set_asynch", 64'(set_asynch), 64'(1));
        run_vec(0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
